fifo_buffer_param: RTL
======================

// Module: fifo_buffer_param
// PURPOSE
//  Parametrised synchronous FIFO, next generation of the SPI_TX data buffer.
//  Configurable width/depth, fill-level output, programmable almost-full/empty
//  thresholds, synchronous flush, sticky overflow/underflow error flags.
//  Sits between the register/bus write side and the SPI_TX shifter read side.
// PARAMETERS
//  DATA_WIDTH  32  data word width, bits (>=1)
//  PTR_WIDTH   3   address bits; DEPTH = 2**PTR_WIDTH (>=1)
//  AF_THRESH   6   ALMOST_FULL asserted when LEVEL >= AF_THRESH (1..DEPTH)
//  AE_THRESH   1   ALMOST_EMPTY asserted when LEVEL <= AE_THRESH (0..DEPTH-1)
// PORTS
//  CLK           in   1            clock, all logic on posedge
//  RST_N         in   1            reset, synchronous, active-low
//  FIFO_WRITE    in   1            write request, DATA_IN pushed if accepted
//  FIFO_READ     in   1            read request, head word popped if accepted
//  FLUSH         in   1            sync clear of contents (pointers only)
//  CLR_ERR       in   1            clear sticky OVERFLOW/UNDERFLOW
//  DATA_IN       in   DATA_WIDTH   write data
//  DATA_OUT      out  DATA_WIDTH   head-of-FIFO data
//  EMPTY         out  1            LEVEL == 0
//  FULL          out  1            LEVEL == DEPTH
//  ALMOST_EMPTY  out  1            LEVEL <= AE_THRESH
//  ALMOST_FULL   out  1            LEVEL >= AF_THRESH
//  LEVEL         out  PTR_WIDTH+1  words stored, 0..DEPTH
//  OVERFLOW      out  1            sticky: write attempted while FULL
//  UNDERFLOW     out  1            sticky: read attempted while EMPTY
// BEHAVIOUR
//  - Pointers WR_PTR/RD_PTR PTR_WIDTH+1 bits, extra MSB = wrap bit; wrap mod 2*DEPTH.
//  - LEVEL = WR_PTR - RD_PTR (mod 2**(PTR_WIDTH+1)); all status outputs
//    combinational from registered pointers/flags, no glitch-free guarantee.
//  - Write accepted iff FIFO_WRITE && !FULL; read accepted iff FIFO_READ && !EMPTY.
//    Acceptance evaluated on state before the edge; no full-bypass.
//  - Simultaneous read+write: both accepted if allowed; LEVEL unchanged.
//    When FULL: read accepted, write rejected, OVERFLOW set.
//    When EMPTY: write accepted, read rejected, UNDERFLOW set.
//  - Rejected write: memory and WR_PTR unchanged. Rejected read: RD_PTR unchanged.
//  - FLUSH (RST_N high): WR_PTR=RD_PTR=0 next edge; overrides same-cycle read/write
//    (neither accepted, no error flagged); memory contents not cleared.
//  - CLR_ERR clears OVERFLOW/UNDERFLOW next edge; a new error in the same cycle
//    wins (flag stays/becomes 1).
//  - RST_N low at posedge: pointers 0, OVERFLOW=UNDERFLOW=0; mid-operation reset
//    discards all data. After reset: EMPTY=1, FULL=0, LEVEL=0, ALMOST_EMPTY=1,
//    ALMOST_FULL=0. Memory has no reset.
//  - Default DATA_OUT: unbuffered, DATA_OUT = mem[RD_PTR[PTR_WIDTH-1:0]]
//    (first-word fall-through, 0-cycle latency); undefined while EMPTY.
// CONFIGURATION
//  FIFO_BUF_REG_OUT_EN defined: DATA_OUT registered; on accepted read DATA_OUT
//    <= popped word, visible 1 cycle after read edge; held otherwise; reset
//    value 0. Adds output DATA_VALID (1 bit): 1 for exactly the cycle after an
//    accepted read, else 0, reset 0. FLUSH does not alter DATA_OUT.
//  Undefined: unbuffered FWFT DATA_OUT as above, no DATA_VALID port.
// TESTING (defaults, DEPTH=8)
//  1. Reset then write 0xA0..0xA7 -> LEVEL 1..8, ALMOST_FULL at 6, FULL at 8;
//     9th write 0xFF rejected, OVERFLOW=1; 8 reads return 0xA0..0xA7 in order.
//  2. Read on empty after reset -> UNDERFLOW=1, LEVEL=0; CLR_ERR pulse -> 0;
//     CLR_ERR with read-on-empty same cycle -> UNDERFLOW stays 1.
//  3. Fill to 8, then read+write 0xB0 same cycle -> read accepted, write
//     rejected, LEVEL=7, OVERFLOW=1; at LEVEL=3 read+write -> LEVEL stays 3.
//  4. Stream 20 words 0x00..0x13, reading 1 per write after 4 pre-fill -> data
//     in order across pointer wrap, LEVEL constant 4, no error flags.
//  5. LEVEL=5, assert FLUSH with FIFO_WRITE=1 -> LEVEL=0, EMPTY=1, no flags;
//     RST_N low 1 edge at LEVEL=5 -> all outputs at reset values.
//  6. FIFO_BUF_REG_OUT_EN: write 0x11,0x22, read twice -> DATA_OUT 0x11 then
//     0x22, each with DATA_VALID=1 one cycle after read edge.

Source files
------------

// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO for the SPI_TX data path, with fill level, almost thresholds and sticky error flags.
// Optional feature macro FIFO_BUF_REG_OUT_EN: registered data_out plus a data_valid strobe.
module fifo_buffer_param #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PTR_WIDTH:0]    level,
  output logic                  overflow,
`ifdef FIFO_BUF_REG_OUT_EN
  output logic                  data_valid,
`endif
  output logic                  underflow
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_L = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] AF_L    = AF_THRESH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_L    = AE_THRESH[PTR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_set;
  logic                  unf_set;

  // Pointer difference wraps naturally thanks to the extra wrap bit.
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_empty = (level <= AE_L);
  assign almost_full  = (level >= AF_L);

  // Flush suppresses both transfers and any error they would raise.
  assign wr_en   = fifo_write && !full  && !flush;
  assign rd_en   = fifo_read  && !empty && !flush;
  assign ovf_set = fifo_write && full   && !flush;
  assign unf_set = fifo_read  && empty  && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_WIDTH-1:0]] <= data_in;
  end

`ifdef FIFO_BUF_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (rd_en) data_out <= mem[rd_ptr[PTR_WIDTH-1:0]];
      data_valid <= rd_en;
    end
  end
`else
  assign data_out = mem[rd_ptr[PTR_WIDTH-1:0]];
`endif

endmodule
